stream_framer: RTL and testbench
================================

STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 Parameter DW, default 128, data word width in bits; SHALL be >= 32.
REQ-002 Parameter META_WORDS, default 2, metadata words appended per frame; range 1..15.
REQ-003 Parameter CNT_W, default 32, frame-counter width; SHALL be <= DW.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 frame_words  in  32  data words per frame; sampled at frame start.
REQ-007 s_data_tdata / s_data_tvalid / s_data_tready  in/in/out  DW/1/1  payload AXI-Stream.
REQ-008 s_meta_tdata / s_meta_tvalid / s_meta_tready  in/in/out  DW/1/1  metadata AXI-Stream.
REQ-009 m_tdata / m_tvalid / m_tready / m_tlast  out/out/in/out  DW/1/1/1  framed output AXI-Stream.
REQ-010 frame_count  out  CNT_W  number of frames fully emitted since reset.
REQ-011 busy  out  1  high when state is not S_DATA or the frame word counter is nonzero.

Function
REQ-012 Output frame order SHALL be: N payload words, META_WORDS metadata words, one trailer word, where N is the latched frame_words.
REQ-013 A frame_words value of 0 SHALL be treated as 1.
REQ-014 frame_words SHALL be latched when the first payload word of a frame is accepted; changes mid-frame SHALL NOT affect the current frame.
REQ-015 The state machine SHALL have three states: S_DATA -> S_META after the Nth payload accept; S_META -> S_TRAIL after the META_WORDS-th meta accept; S_TRAIL -> S_DATA when the trailer loads into the output register.
REQ-016 The output SHALL be one registered stage; the register loads when !m_tvalid || m_tready.
REQ-017 s_data_tready SHALL equal (state==S_DATA) && (!m_tvalid || m_tready).
REQ-018 s_meta_tready SHALL equal (state==S_META) && (!m_tvalid || m_tready).
REQ-019 A word SHALL transfer on any channel only when valid && ready are both high in the same cycle.
REQ-020 Latency from input accept to m_tvalid SHALL be 1 cycle.
REQ-021 Full throughput SHALL be one word per cycle while m_tready=1 and the active input is valid.
REQ-022 Trailer tdata SHALL be the current frame_count, zero-extended to DW.
REQ-023 m_tlast SHALL be 1 only on the trailer word.
REQ-024 frame_count SHALL increment by 1 when the trailer transfers (m_tvalid && m_tready && m_tlast) and wrap modulo 2^CNT_W.
REQ-025 m_tdata, m_tvalid and m_tlast SHALL hold stable while m_tvalid && !m_tready.
REQ-026 Meta words arriving during S_DATA SHALL be stalled (s_meta_tready=0) and never dropped or reordered.
REQ-027 Payload words arriving outside S_DATA SHALL likewise be stalled, never dropped or reordered.
REQ-028 The payload word counter SHALL be 32 bits and the meta counter 4 bits; neither SHALL overflow for legal parameters.

Reset
REQ-029 While resetn=0, state SHALL be S_DATA and all counters SHALL be 0.
REQ-030 While resetn=0, m_tvalid, m_tlast, m_tdata, frame_count and busy SHALL be 0.
REQ-031 While resetn=0, s_data_tready and s_meta_tready SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame and any held output word; after release, output SHALL restart with a fresh frame's payload.

Structure
REQ-033 The state encoding (S_DATA, S_META, S_TRAIL) SHALL live in shared package stream_pkg.
REQ-034 The shared package SHALL also hold the counter width constants.
REQ-035 The output register SHALL be sub-module axis_out_reg (DW+1 bits: tdata plus tlast) with valid/ready.

Verification
REQ-036 frame_words=4, META_WORDS=2, m_tready=1, inputs always valid -> 7-beat frame D0..D3,M0,M1,trailer 0; tlast on beat 7; frame_count=1.
REQ-037 Same setup, m_tready toggling 1010... -> identical 7-word sequence; no duplication or loss; outputs stable while stalled.
REQ-038 Meta valid asserted from cycle 0 -> s_meta_tready=0 until the 4th payload accept; meta order preserved.
REQ-039 frame_words=0 -> 1 payload word + 2 meta + trailer per frame; 3 back-to-back frames -> trailers 0,1,2.
REQ-040 CNT_W=2, 5 frames -> trailers 0,1,2,3,0.
REQ-041 resetn pulsed low after 2 payload words -> all outputs 0 during reset; next frame begins with fresh payload; frame_count=0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream framer: FSM encoding, counter widths and
// the frame-length helper used when a frame starts.
package stream_pkg;

    typedef enum logic [1:0] {
        S_DATA  = 2'd0,
        S_META  = 2'd1,
        S_TRAIL = 2'd2
    } state_t;

    localparam int WORD_CNT_W = 32;
    localparam int META_CNT_W = 4;

    // A requested length of zero still produces one payload word.
    function automatic logic [WORD_CNT_W-1:0] eff_words(input logic [WORD_CNT_W-1:0] fw);
        return (fw == '0) ? WORD_CNT_W'(1) : fw;
    endfunction

endpackage

// File: rtl/stream_framer_if.sv
// AXI-Stream style bundle used for the framer's payload, metadata and output.
// A word moves only in a cycle where tvalid && tready are both high; the
// source holds tdata/tvalid/tlast steady until that happens.
interface stream_framer_if #(
    parameter int DW = 128
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/stream_framer_axis_out_reg.sv
// Single registered output stage with valid/ready; carries tdata plus tlast.
module axis_out_reg #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/stream_framer.sv
// Frames a payload stream: N payload words, META_WORDS metadata words, then a
// trailer carrying the running frame count (tlast set on the trailer only).
module stream_framer
    import stream_pkg::*;
#(
    parameter int DW         = 128,
    parameter int META_WORDS = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [WORD_CNT_W-1:0] frame_words,
    stream_framer_if.slave        s_data,
    stream_framer_if.slave        s_meta,
    stream_framer_if.master       m,
    output logic [CNT_W-1:0]      frame_count,
    output logic                  busy,
    output state_t                dbg_state
);

    state_t                  state, state_nxt;
    logic [WORD_CNT_W-1:0]   word_cnt, word_cnt_nxt;
    logic [WORD_CNT_W-1:0]   n_lat, n_lat_nxt, n_cur;
    logic [META_CNT_W-1:0]   meta_cnt, meta_cnt_nxt;
    logic [CNT_W-1:0]        fc;
    logic [DW-1:0]           trailer;

    logic                    load_ready;
    logic                    reg_in_valid;
    logic [DW:0]             reg_in_data;
    logic                    reg_out_valid;
    logic [DW:0]             reg_out_data;
    logic                    data_fire, meta_fire, trail_fire;

    assign s_data.tready = resetn && (state == S_DATA) && load_ready;
    assign s_meta.tready = resetn && (state == S_META) && load_ready;
    assign data_fire     = s_data.tvalid && s_data.tready;
    assign meta_fire     = s_meta.tvalid && s_meta.tready;
    assign trail_fire    = reg_out_valid && m.tready && reg_out_data[DW];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_DATA;
            word_cnt <= '0;
            n_lat    <= '0;
            meta_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            n_lat    <= n_lat_nxt;
            meta_cnt <= meta_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        word_cnt_nxt       = word_cnt;
        n_lat_nxt          = n_lat;
        meta_cnt_nxt       = meta_cnt;
        reg_in_valid       = 1'b0;
        reg_in_data        = '0;
        trailer            = '0;
        trailer[CNT_W-1:0] = fc;
        // The frame length is taken from frame_words only on the first accept.
        n_cur = (word_cnt == '0) ? eff_words(frame_words) : n_lat;

        case (state)
            S_DATA: begin
                reg_in_valid = s_data.tvalid;
                reg_in_data  = {1'b0, s_data.tdata};
                if (data_fire) begin
                    if (word_cnt == '0) begin
                        n_lat_nxt = n_cur;
                    end
                    if (word_cnt + WORD_CNT_W'(1) == n_cur) begin
                        word_cnt_nxt = '0;
                        state_nxt    = S_META;
                    end else begin
                        word_cnt_nxt = word_cnt + WORD_CNT_W'(1);
                    end
                end
            end
            S_META: begin
                reg_in_valid = s_meta.tvalid;
                reg_in_data  = {1'b0, s_meta.tdata};
                if (meta_fire) begin
                    if (meta_cnt == META_CNT_W'(META_WORDS - 1)) begin
                        meta_cnt_nxt = '0;
                        state_nxt    = S_TRAIL;
                    end else begin
                        meta_cnt_nxt = meta_cnt + META_CNT_W'(1);
                    end
                end
            end
            S_TRAIL: begin
                reg_in_valid = 1'b1;
                reg_in_data  = {1'b1, trailer};
                if (load_ready) begin
                    state_nxt = S_DATA;
                end
            end
            default: begin
                state_nxt = S_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fc <= '0;
        end else if (trail_fire) begin
            fc <= fc + CNT_W'(1);
        end
    end

    axis_out_reg #(.W(DW + 1)) u_out_reg (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (reg_in_valid),
        .in_ready  (load_ready),
        .in_data   (reg_in_data),
        .out_valid (reg_out_valid),
        .out_ready (m.tready),
        .out_data  (reg_out_data)
    );

    // Outputs are forced low for the whole reset window, not just after an edge.
    assign m.tvalid    = resetn && reg_out_valid;
    assign m.tlast     = resetn && reg_out_data[DW];
    assign m.tdata     = resetn ? reg_out_data[DW-1:0] : '0;
    assign frame_count = resetn ? fc : '0;
    assign busy        = resetn && ((state != S_DATA) || (word_cnt != '0));
    assign dbg_state   = state;

endmodule

// File: tb/tb_stream_framer.sv
// Bench for stream_framer: two instances (32-bit and 2-bit frame counters) fed
// identical streams and scored against frames built from the planned traffic.
module tb_stream_framer;
    import stream_pkg::*;

    localparam int  DW    = 64;
    localparam int  MW    = 2;
    localparam time CLK_P = 10;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   fw;
    } pay_t;

    // clock / reset
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    logic [31:0]   frame_words;
    logic          d_valid, mt_valid, out_ready;
    logic [DW-1:0] d_data, mt_data;
    logic [31:0]   fc_a;
    logic [1:0]    fc_b;
    logic          busy_a, busy_b;
    state_t        st_a, st_b;

    stream_framer_if #(.DW(DW)) sd_a ();
    stream_framer_if #(.DW(DW)) sm_a ();
    stream_framer_if #(.DW(DW)) mo_a ();
    stream_framer_if #(.DW(DW)) sd_b ();
    stream_framer_if #(.DW(DW)) sm_b ();
    stream_framer_if #(.DW(DW)) mo_b ();

    assign sd_a.tdata = d_data;   assign sd_a.tvalid = d_valid;  assign sd_a.tlast = 1'b0;
    assign sd_b.tdata = d_data;   assign sd_b.tvalid = d_valid;  assign sd_b.tlast = 1'b0;
    assign sm_a.tdata = mt_data;  assign sm_a.tvalid = mt_valid; assign sm_a.tlast = 1'b0;
    assign sm_b.tdata = mt_data;  assign sm_b.tvalid = mt_valid; assign sm_b.tlast = 1'b0;
    assign mo_a.tready = out_ready;
    assign mo_b.tready = out_ready;

    stream_framer #(.DW(DW), .META_WORDS(MW), .CNT_W(32)) dut_a (
        .clk(clk), .resetn(resetn), .frame_words(frame_words),
        .s_data(sd_a), .s_meta(sm_a), .m(mo_a),
        .frame_count(fc_a), .busy(busy_a), .dbg_state(st_a)
    );

    stream_framer #(.DW(DW), .META_WORDS(MW), .CNT_W(2)) dut_b (
        .clk(clk), .resetn(resetn), .frame_words(frame_words),
        .s_data(sd_b), .s_meta(sm_b), .m(mo_b),
        .frame_count(fc_b), .busy(busy_b), .dbg_state(st_b)
    );

    // scoreboard state
    int            errors = 0;
    int            checks = 0;
    pay_t          pay_q[$];
    logic [DW-1:0] meta_q[$];
    logic [DW:0]   exp_q_a[$];
    logic [DW:0]   exp_q_b[$];
    int            n_q[$];
    int            frame_idx;
    int            cur_n, acc_cnt, meta_seen;
    bit            d_gap, mt_gap;
    int            ready_mode;
    bit            stall[2];
    logic [DW:0]   held[2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: a frame is n payload words, MW meta words, then frame index.
    task automatic plan_frame(input logic [31:0] fw, input bit noise);
        int            n;
        logic [DW-1:0] w;
        logic [DW:0]   tr_a, tr_b;
        pay_t          p;
        n = (fw == 0) ? 1 : int'(fw);
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            p.data = w;
            p.fw   = (i == 0 || !noise) ? fw : $urandom;
            pay_q.push_back(p);
            exp_q_a.push_back({1'b0, w});
            exp_q_b.push_back({1'b0, w});
        end
        for (int i = 0; i < MW; i++) begin
            w = {$urandom, $urandom};
            meta_q.push_back(w);
            exp_q_a.push_back({1'b0, w});
            exp_q_b.push_back({1'b0, w});
        end
        tr_a = '0; tr_a[DW] = 1'b1; tr_a[31:0] = 32'(frame_idx);
        tr_b = '0; tr_b[DW] = 1'b1; tr_b[1:0]  = 2'(frame_idx % 4);
        exp_q_a.push_back(tr_a);
        exp_q_b.push_back(tr_b);
        n_q.push_back(n);
        frame_idx++;
    endtask

    task automatic check_beat(input int side, input string sfx, input logic v, input logic [DW:0] beat);
        logic [DW:0] e;
        bit          have;
        if (stall[side]) begin
            check({"hold_valid", sfx}, v, 1'b1);
            check({"hold_beat", sfx}, beat, held[side]);
        end
        if (v && out_ready) begin
            have = (side == 1) ? (exp_q_b.size() != 0) : (exp_q_a.size() != 0);
            checks++;
            assert (have) else begin
                errors++;
                $error("FAIL extra_beat%s: observed %0h, required no beat", sfx, beat);
            end
            if (have) begin
                e = (side == 1) ? exp_q_b.pop_front() : exp_q_a.pop_front();
                check({"beat", sfx}, beat, e);
            end
        end
        stall[side] = v && !out_ready;
        held[side]  = beat;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tvalid_a"}, mo_a.tvalid, 1'b0);
        check({tag, "_tlast_a"},  mo_a.tlast,  1'b0);
        check({tag, "_tdata_a"},  mo_a.tdata,  '0);
        check({tag, "_fc_a"},     fc_a,        '0);
        check({tag, "_busy_a"},   busy_a,      1'b0);
        check({tag, "_dready_a"}, sd_a.tready, 1'b0);
        check({tag, "_mready_a"}, sm_a.tready, 1'b0);
        check({tag, "_tvalid_b"}, mo_b.tvalid, 1'b0);
        check({tag, "_tdata_b"},  mo_b.tdata,  '0);
        check({tag, "_fc_b"},     fc_b,        '0);
        check({tag, "_dready_b"}, sd_b.tready, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        check({tag, "_drain_a"}, exp_q_a.size(), 0);
        check({tag, "_drain_b"}, exp_q_b.size(), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input string tag, input logic [31:0] exp_fc);
        check({tag, "_fc_a"},     fc_a, exp_fc);
        check({tag, "_fc_b"},     fc_b, exp_fc[1:0]);
        check({tag, "_busy_a"},   busy_a, 1'b0);
        check({tag, "_tvalid_a"}, mo_a.tvalid, 1'b0);
        check({tag, "_state_a"},  st_a, S_DATA);
    endtask

    // driver tasks: sample handshakes on negedge, update stimulus 1 after posedge
    initial begin : bfm
        bit d_acc, mt_acc;
        d_valid = 1'b0; d_data = '0; frame_words = '0;
        mt_valid = 1'b0; mt_data = '0; out_ready = 1'b1;
        forever begin
            @(negedge clk);
            d_acc  = d_valid && sd_a.tready;
            mt_acc = mt_valid && sm_a.tready;
            if (resetn) begin
                if (acc_cnt < cur_n || meta_seen == MW) check("meta_stall", sm_a.tready, 1'b0);
                if (acc_cnt == cur_n && meta_seen < MW) check("data_stall", sd_a.tready, 1'b0);
                if (d_acc) begin
                    if (acc_cnt == cur_n && meta_seen == MW) begin
                        cur_n     = (n_q.size() != 0) ? n_q.pop_front() : 1;
                        acc_cnt   = 1;
                        meta_seen = 0;
                    end else begin
                        acc_cnt++;
                    end
                end
                if (mt_acc) meta_seen++;
                check_beat(0, "_a", mo_a.tvalid, {mo_a.tlast, mo_a.tdata});
                check_beat(1, "_b", mo_b.tvalid, {mo_b.tlast, mo_b.tdata});
            end else begin
                stall[0] = 1'b0;
                stall[1] = 1'b0;
            end
            @(posedge clk);
            #1;
            if (d_acc) void'(pay_q.pop_front());
            if (!(d_valid && !d_acc)) begin
                if (pay_q.size() != 0 && (!d_gap || $urandom_range(0, 3) != 0)) begin
                    d_valid     = 1'b1;
                    d_data      = pay_q[0].data;
                    frame_words = pay_q[0].fw;
                end else begin
                    d_valid = 1'b0;
                end
            end
            if (mt_acc) void'(meta_q.pop_front());
            if (!(mt_valid && !mt_acc)) begin
                if (meta_q.size() != 0 && (!mt_gap || $urandom_range(0, 3) != 0)) begin
                    mt_valid = 1'b1;
                    mt_data  = meta_q[0];
                end else begin
                    mt_valid = 1'b0;
                end
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !out_ready;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin : main
        int c;
        ready_mode = 0; d_gap = 1'b0; mt_gap = 1'b0;
        frame_idx = 0; cur_n = 0; acc_cnt = 0; meta_seen = MW;
        resetn = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #3;
            check_reset("rst");
        end
        @(posedge clk);
        #2;
        resetn = 1'b1;

        // single 4-word frame, sink always ready, meta valid from the start
        plan_frame(32'd4, 1'b0);
        wait_done("f4", 200);
        check_idle("f4", 32'd1);

        // same frame with the sink toggling every cycle
        ready_mode = 1;
        plan_frame(32'd4, 1'b0);
        wait_done("tog", 200);
        check_idle("tog", 32'd2);

        // zero-length requests, three frames back to back; counter B wraps here
        ready_mode = 0;
        repeat (3) plan_frame(32'd0, 1'b0);
        wait_done("fw0", 200);
        check_idle("fw0", 32'd5);

        // random lengths, random gaps, random sink, frame_words churn mid-frame
        ready_mode = 2; d_gap = 1'b1; mt_gap = 1'b1;
        for (int f = 0; f < 20; f++) plan_frame(32'($urandom_range(0, 6)), 1'b1);
        wait_done("rnd", 5000);
        check_idle("rnd", 32'd25);

        // reset after two payload words of a frame
        ready_mode = 0; d_gap = 1'b0; mt_gap = 1'b0;
        @(posedge clk);
        #2;
        plan_frame(32'd4, 1'b0);
        c = 0;
        while (!(cur_n == 4 && acc_cnt == 2 && meta_seen == 0) && c < 100) begin
            @(posedge clk);
            #2;
            c++;
        end
        check("mid_reach", c < 100, 1'b1);
        check("mid_busy_a", busy_a, 1'b1);
        resetn = 1'b0;
        pay_q.delete(); meta_q.delete(); exp_q_a.delete(); exp_q_b.delete(); n_q.delete();
        d_valid = 1'b0; mt_valid = 1'b0;
        frame_idx = 0; cur_n = 0; acc_cnt = 0; meta_seen = MW;
        #1;
        check_reset("mrst0");
        repeat (2) begin
            @(posedge clk);
            #3;
            check_reset("mrst");
        end
        @(posedge clk);
        #2;
        resetn = 1'b1;
        plan_frame(32'd3, 1'b0);
        wait_done("post", 200);
        check_idle("post", 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #(CLK_P * 40000);
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
